// File: rtl/data_memory_arbiter.sv
// -----------------------------------------------------------------------------
// data_memory_arbiter
//   Shares one single-port, byte-addressed 64-bit data memory between the CPU
//   load/store stage (cpu_*) and the program/debug loader (dma_*).
//   A request is accepted in IDLE and latched. It then gets exactly one memory
//   strobe cycle (ACCESS), and completes with a done pulse and registered read
//   data (DONE). Grant to done takes 2 cycles. A rejected access skips ACCESS,
//   so its done and error follow 1 cycle after the grant.
//   Arbitration is round-robin. On a tie the requester not granted last wins.
//
// Configuration macro:
//   ALIGN_CHECK_EN - when defined, addresses with address[2:0] != 0 are
//                    rejected in the same way as out-of-range addresses.
//
// Ports:
//   clock, reset           rising-edge clock, asynchronous active-high reset
//   cpu_req/dma_req        level requests, sampled only in IDLE
//   *_write                1 = store, 0 = load
//   *_address, *_wdata     byte address and store data of the 8-byte access
//   *_grant                1-cycle pulse when the command is latched
//   *_done                 1-cycle pulse when the access completes
//   *_rdata                load data while done (0 for a store or a reject)
//   error                  qualifies done: the access was rejected without a strobe
//   mem_read/mem_write     memory strobes, high only in ACCESS
//   mem_address/mem_wdata  latched command towards the memory
//   mem_rdata              combinational memory read data
// -----------------------------------------------------------------------------
module data_memory_arbiter #(
    parameter int MEM_SIZE   = 256,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_write,
    input  logic [ADDR_WIDTH-1:0] cpu_address,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_grant,
    output logic                  cpu_done,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  dma_req,
    input  logic                  dma_write,
    input  logic [ADDR_WIDTH-1:0] dma_address,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_grant,
    output logic                  dma_done,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic                  error,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // One bit wider than the address so that address+7 cannot wrap.
    localparam logic [ADDR_WIDTH:0] LAST_OFS_C  = (ADDR_WIDTH+1)'(7);
    localparam logic [ADDR_WIDTH:0] MEM_LIMIT_C = (ADDR_WIDTH+1)'(MEM_SIZE);

    logic [1:0]            state_q, state_d;
    logic                  owner_q;       // 1 = DMA owns the current access
    logic                  last_grant_q;  // 1 = DMA was granted last
    logic                  write_q;
    logic                  error_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  any_req_s;
    logic                  sel_dma_s;
    logic                  req_write_s;
    logic [ADDR_WIDTH-1:0] req_addr_s;
    logic [DATA_WIDTH-1:0] req_wdata_s;
    logic                  reject_s;

    // Rejects an access whose last byte lies outside the memory, wrap included.
    function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH:0] last_byte;
        last_byte = {1'b0, addr} + LAST_OFS_C;
        return (last_byte >= MEM_LIMIT_C);
    endfunction

    // Round-robin select and mux of the winning command.
    always_comb begin
        any_req_s   = cpu_req | dma_req;
        // DMA wins alone, or on a tie when the CPU was granted last.
        sel_dma_s   = dma_req & (~cpu_req | ~last_grant_q);
        req_write_s = sel_dma_s ? dma_write   : cpu_write;
        req_addr_s  = sel_dma_s ? dma_address : cpu_address;
        req_wdata_s = sel_dma_s ? dma_wdata   : cpu_wdata;
`ifdef ALIGN_CHECK_EN
        reject_s    = out_of_range(req_addr_s) | (req_addr_s[2:0] != 3'd0);
`else
        reject_s    = out_of_range(req_addr_s);
`endif
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_d = reject_s ? ST_DONE : ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs. The grant is gated by reset because it decodes live request inputs.
    always_comb begin
        cpu_grant = 1'b0;
        dma_grant = 1'b0;
        cpu_done  = 1'b0;
        dma_done  = 1'b0;
        error     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req_s && !reset) begin
                    cpu_grant = ~sel_dma_s;
                    dma_grant = sel_dma_s;
                end else begin
                    cpu_grant = 1'b0;
                    dma_grant = 1'b0;
                end
            end
            ST_ACCESS: begin
                mem_read  = ~write_q;
                mem_write = write_q;
            end
            ST_DONE: begin
                cpu_done = ~owner_q;
                dma_done = owner_q;
                error    = error_q;
            end
            default: begin
                cpu_grant = 1'b0;
            end
        endcase
        // rdata_q is cleared whenever ownership changes, so the non-owner always sees 0.
        cpu_rdata   = owner_q ? {DATA_WIDTH{1'b0}} : rdata_q;
        dma_rdata   = owner_q ? rdata_q : {DATA_WIDTH{1'b0}};
        mem_address = addr_q;
        mem_wdata   = wdata_q;
    end

    // Command latch at grant, and read-data capture at the end of ACCESS.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            write_q      <= 1'b0;
            error_q      <= 1'b0;
            addr_q       <= {ADDR_WIDTH{1'b0}};
            wdata_q      <= {DATA_WIDTH{1'b0}};
            rdata_q      <= {DATA_WIDTH{1'b0}};
        end else if (state_q == ST_IDLE && any_req_s) begin
            owner_q      <= sel_dma_s;
            last_grant_q <= sel_dma_s;
            write_q      <= req_write_s;
            error_q      <= reject_s;
            addr_q       <= req_addr_s;
            wdata_q      <= req_wdata_s;
            rdata_q      <= {DATA_WIDTH{1'b0}};
        end else if (state_q == ST_ACCESS && !write_q) begin
            rdata_q      <= mem_rdata;
        end else begin
            rdata_q      <= rdata_q;
        end
    end

endmodule
